// File: rtl/mole_game_core.sv
// Whack-a-mole engine: LFSR mole patterns, keypad scoring, combo/fever mode, round timer.
// Optional MOLE_MISS_PENALTY_EN: a miss in PLAY/FEVER also takes one point off the score (floored at 0).
module mole_game_core #(
  parameter int N_HOLES      = 8,
  parameter int SCORE_W      = 8,
  parameter int COMBO_W      = 4,
  parameter int TICK_DIV     = 25000000,
  parameter int GAME_TICKS   = 45,
  parameter int FEVER_COMBO  = 10,
  parameter int FEVER_ROUNDS = 3,
  parameter int HIT_PTS      = 1,
  parameter int FEVER_PTS    = 3
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               start,
  input  logic [N_HOLES-1:0] keypad,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [7:0]         timer,
  output logic               fever,
  output logic               game_over,
  output logic               hit,
  output logic               miss
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int FC_W   = $clog2(FEVER_ROUNDS + 1);
  localparam int HALF   = N_HOLES / 2;

  localparam logic [N_HOLES-1:0] LOW_MASK  = {{(N_HOLES-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [N_HOLES-1:0] HIGH_MASK = ~LOW_MASK;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]         TIMER_INIT = 8'(GAME_TICKS);

  typedef enum logic [1:0] {IDLE, PLAY, FEVER, OVER} state_t;

  state_t             state, state_n;
  logic [15:0]        lfsr;
  logic [TICK_W-1:0]  tick_cnt, tick_cnt_n;
  logic [FC_W-1:0]    fever_cnt, fever_cnt_n;
  logic [N_HOLES-1:0] key_prev;

  logic [N_HOLES-1:0] mole_n;
  logic [SCORE_W-1:0] score_n;
  logic [COMBO_W-1:0] combo_n;
  logic [7:0]         timer_n;
  logic               fever_n, game_over_n, hit_n, miss_n;

  logic [N_HOLES-1:0] pat, rise;
  logic               one_press, lit, tick_pulse, start_game, last_tick;
  logic [SCORE_W:0]   hit_sum, fever_sum;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W-1:0] score_hit, score_fever, score_miss;
  logic [COMBO_W-1:0] combo_inc;

  assign pat = (lfsr[N_HOLES-1:0] == '0) ? N_HOLES'(1) : lfsr[N_HOLES-1:0];

  // Exactly one new edge counts as a press; simultaneous edges are discarded.
  assign rise      = keypad & ~key_prev;
  assign one_press = (rise != '0) && ((rise & (rise - N_HOLES'(1))) == '0);
  assign lit       = (rise & mole) != '0;

  assign tick_pulse = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign last_tick  = tick_pulse && (timer == 8'd1);
  assign start_game = ((state == IDLE) || (state == OVER)) && start;

  assign hit_sum     = {1'b0, score} + (SCORE_W+1)'(HIT_PTS);
  assign fever_sum   = {1'b0, score} + (SCORE_W+1)'(FEVER_PTS);
  assign combo_sum   = {1'b0, combo} + (COMBO_W+1)'(1);
  assign score_hit   = hit_sum[SCORE_W]   ? '1 : hit_sum[SCORE_W-1:0];
  assign score_fever = fever_sum[SCORE_W] ? '1 : fever_sum[SCORE_W-1:0];
  assign combo_inc   = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];

`ifdef MOLE_MISS_PENALTY_EN
  assign score_miss = (score == '0) ? '0 : score - SCORE_W'(1);
`else
  assign score_miss = score;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n     = state;
    mole_n      = mole;
    score_n     = score;
    combo_n     = combo;
    timer_n     = timer;
    fever_n     = fever;
    game_over_n = game_over;
    fever_cnt_n = fever_cnt;
    hit_n       = 1'b0;
    miss_n      = 1'b0;

    if (state == IDLE || start_game) tick_cnt_n = '0;
    else if (tick_pulse)             tick_cnt_n = '0;
    else                             tick_cnt_n = tick_cnt + TICK_W'(1);

    unique case (state)
      IDLE: mole_n = '0;

      PLAY: begin
        if (one_press && lit) begin
          hit_n   = 1'b1;
          score_n = score_hit;
          combo_n = combo_inc;
          mole_n  = mole & ~rise;
        end else if (one_press) begin
          miss_n  = 1'b1;
          combo_n = '0;
          score_n = score_miss;
        end
        if (tick_pulse) begin
          timer_n = timer - 8'd1;
          mole_n  = pat;
        end
        // The final tick outranks a fever trigger on the same cycle.
        if (last_tick) begin
          state_n     = OVER;
          mole_n      = '0;
          fever_n     = 1'b0;
          game_over_n = 1'b1;
        end else if (combo_n >= COMBO_W'(FEVER_COMBO)) begin
          state_n     = FEVER;
          fever_cnt_n = '0;
          fever_n     = 1'b1;
          mole_n      = LOW_MASK;
        end
      end

      FEVER: begin
        if (one_press && lit) begin
          hit_n   = 1'b1;
          score_n = score_fever;
          combo_n = combo_inc;
          mole_n  = mole & ~rise;
        end else if (one_press) begin
          miss_n  = 1'b1;
          score_n = score_miss;
        end
        if (tick_pulse) begin
          timer_n     = timer - 8'd1;
          fever_cnt_n = fever_cnt + FC_W'(1);
          if (last_tick) begin
            state_n     = OVER;
            mole_n      = '0;
            fever_n     = 1'b0;
            game_over_n = 1'b1;
          end else if (fever_cnt_n == FC_W'(FEVER_ROUNDS)) begin
            state_n = PLAY;
            combo_n = '0;
            fever_n = 1'b0;
            mole_n  = pat;
          end else begin
            mole_n = fever_cnt_n[0] ? HIGH_MASK : LOW_MASK;
          end
        end
      end

      OVER: begin
        if (tick_pulse) mole_n = (mole == '0) ? '1 : '0;
      end

      default: state_n = IDLE;
    endcase

    if (start_game) begin
      state_n     = PLAY;
      mole_n      = pat;
      score_n     = '0;
      combo_n     = '0;
      timer_n     = TIMER_INIT;
      fever_n     = 1'b0;
      game_over_n = 1'b0;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    lfsr     <= RESET ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    key_prev <= keypad;
    if (RESET) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      fever_cnt <= '0;
      mole      <= '0;
      score     <= '0;
      combo     <= '0;
      timer     <= TIMER_INIT;
      fever     <= 1'b0;
      game_over <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      fever_cnt <= fever_cnt_n;
      mole      <= mole_n;
      score     <= score_n;
      combo     <= combo_n;
      timer     <= timer_n;
      fever     <= fever_n;
      game_over <= game_over_n;
      hit       <= hit_n;
      miss      <= miss_n;
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core (TICK_DIV=4, GAME_TICKS=30); mole patterns come from a
// local model of the 16-bit LFSR, everything else from hand-derived expectations.
module tb_mole_game_core;

  localparam int TICK_DIV   = 4;
  localparam int GAME_TICKS = 30;

  logic       clk = 1'b0;
  logic       RESET, start;
  logic [7:0] keypad;
  logic [7:0] mole;
  logic [7:0] score;
  logic [3:0] combo;
  logic [7:0] timer;
  logic       fever, game_over, hit, miss;

  mole_game_core #(.TICK_DIV(TICK_DIV), .GAME_TICKS(GAME_TICKS)) dut (
    .clk(clk), .RESET(RESET), .start(start), .keypad(keypad),
    .mole(mole), .score(score), .combo(combo), .timer(timer),
    .fever(fever), .game_over(game_over), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1 on reset.
  logic [15:0] m_lfsr;
  always @(posedge clk)
    if (RESET) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] keys;
    logic [7:0] mole;
    logic [7:0] score;
    logic [3:0] combo;
    logic [7:0] timer;
    logic       hit;
    logic       miss;
    logic       over;
  } vec_t;

  vec_t       vecs[6];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         t, ticks, hits;
  logic       last_tick;
  logic [7:0] prev_keys, exp_mole, exp_score, key, pp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_of(input logic [15:0] l);
    return (l[7:0] == 8'h00) ? 8'h01 : l[7:0];
  endfunction

  function automatic logic [7:0] lowest(input logic [7:0] x);
    return x & (~x + 8'd1);
  endfunction

  function automatic logic [7:0] after_miss(input logic [7:0] s);
`ifdef MOLE_MISS_PENALTY_EN
    return (s == 8'd0) ? 8'd0 : s - 8'd1;
`else
    return s;
`endif
  endfunction

  // One clock: drive at the negedge, sample at the following negedge.
  task automatic step(input logic [7:0] keys);
    keypad    = keys;
    last_tick = ((t + 1) % TICK_DIV) == 0;
    @(posedge clk);
    @(negedge clk);
    t++;
    if (last_tick) ticks++;
    prev_keys = keys;
  endtask

  // Step in PLAY while tracking the expected mole pattern.
  task automatic play_cycle(input logic [7:0] keys);
    logic [7:0] pat_pre, rise;
    pat_pre = pat_of(m_lfsr);
    rise    = keys & ~prev_keys;
    step(keys);
    if (rise != 8'd0 && (rise & (rise - 8'd1)) == 8'd0 && (rise & exp_mole) != 8'd0)
      exp_mole = exp_mole & ~rise;
    if (last_tick) exp_mole = pat_pre;
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; keypad = 8'h00;
    prev_keys = 8'h00; t = 0; ticks = 0;

    //            rst   st    keys   mole   score  combo timer        hit   miss  over
    vecs[0] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h06, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'd0, 4'd0, 8'(GAME_TICKS), 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      RESET = vecs[i].rst;
      start = vecs[i].st;
      step(vecs[i].keys);
      check($sformatf("vec%0d_mole", i),  mole,      vecs[i].mole);
      check($sformatf("vec%0d_score", i), score,     vecs[i].score);
      check($sformatf("vec%0d_combo", i), combo,     vecs[i].combo);
      check($sformatf("vec%0d_timer", i), timer,     vecs[i].timer);
      check($sformatf("vec%0d_hit", i),   hit,       vecs[i].hit);
      check($sformatf("vec%0d_miss", i),  miss,      vecs[i].miss);
      check($sformatf("vec%0d_over", i),  game_over, vecs[i].over);
      check($sformatf("vec%0d_fever", i), fever,     1'b0);
    end

    // Start a game.
    pp = pat_of(m_lfsr);
    start = 1'b1;
    step(8'h00);
    start = 1'b0;
    t = 0; ticks = 0; exp_mole = pp; exp_score = 8'd0;
    check("start_mole", mole, exp_mole);
    check("start_timer", timer, GAME_TICKS);
    check("start_over", game_over, 1'b0);

    // Hit the lowest lit hole, then miss on a dark one.
    key = lowest(exp_mole);
    play_cycle(key);
    exp_score = 8'd1;
    check("hit1_pulse", hit, 1'b1);
    check("hit1_miss", miss, 1'b0);
    check("hit1_score", score, exp_score);
    check("hit1_combo", combo, 4'd1);
    check("hit1_mole", mole, exp_mole);
    play_cycle(8'h00);
    check("hit1_pulse_end", hit, 1'b0);
    key = lowest(~exp_mole);
    play_cycle(key);
    exp_score = after_miss(exp_score);
    check("miss1_pulse", miss, 1'b1);
    check("miss1_hit", hit, 1'b0);
    check("miss1_combo", combo, 4'd0);
    check("miss1_score", score, exp_score);
    check("miss1_mole", mole, exp_mole);
    play_cycle(8'h00);
    check("miss1_pulse_end", miss, 1'b0);
    check("tick1_timer", timer, GAME_TICKS - 1);
    check("tick1_mole", mole, exp_mole);

    // Ten consecutive hits trigger fever.
    hits = 0;
    for (int i = 0; i < 200 && hits < 10; i++) begin
      if (prev_keys == 8'h00 && exp_mole != 8'h00) begin
        key = lowest(exp_mole);
        play_cycle(key);
        hits++;
        exp_score = exp_score + 8'd1;
        check($sformatf("build_hit%0d", hits), hit, 1'b1);
      end else begin
        play_cycle(8'h00);
      end
    end
    check("build_hits_done", hits, 10);
    check("fever_on", fever, 1'b1);
    check("fever_low_mask", mole, 8'h0F);
    check("fever_entry_score", score, exp_score);
    check("fever_entry_combo", combo, 4'd10);

    // Fever: next tick shows the upper half, one fever hit, then exit after three ticks.
    step(8'h00);
    for (int i = 0; i < 8 && !last_tick; i++) step(8'h00);
    check("fever_tick1_seen", last_tick, 1'b1);
    check("fever_high_mask", mole, 8'hF0);
    step(8'h10);
    exp_score = exp_score + 8'd3;
    check("fever_hit_pulse", hit, 1'b1);
    check("fever_hit_score", score, exp_score);
    check("fever_hit_mole", mole, 8'hE0);
    step(8'h00);
    for (int i = 0; i < 8 && !last_tick; i++) step(8'h00);
    check("fever_tick2_seen", last_tick, 1'b1);
    check("fever_low_again", mole, 8'h0F);
    check("fever_still_on", fever, 1'b1);
    last_tick = 1'b0;
    for (int i = 0; i < 8 && !last_tick; i++) begin
      pp = pat_of(m_lfsr);
      step(8'h00);
    end
    check("fever_tick3_seen", last_tick, 1'b1);
    exp_mole = pp;
    check("fever_off", fever, 1'b0);
    check("fever_exit_combo", combo, 4'd0);
    check("fever_exit_mole", mole, exp_mole);
    check("fever_exit_timer", timer, GAME_TICKS - ticks);

    // Two keys rising together are ignored.
    key = lowest(exp_mole);
    play_cycle(key);
    exp_score = exp_score + 8'd1;
    check("pre2_hit", hit, 1'b1);
    check("pre2_combo", combo, 4'd1);
    play_cycle(8'h00);
    play_cycle(8'h03);
    check("two_keys_hit", hit, 1'b0);
    check("two_keys_miss", miss, 1'b0);
    check("two_keys_score", score, exp_score);
    check("two_keys_combo", combo, 4'd1);
    check("two_keys_mole", mole, exp_mole);

    // Run to expiry and exercise the game-over blink.
    for (int i = 0; i < 400 && ticks < GAME_TICKS; i++) step(8'h00);
    check("expiry_ticks", ticks, GAME_TICKS);
    check("over_flag", game_over, 1'b1);
    check("over_timer", timer, 8'd0);
    check("over_mole", mole, 8'h00);
    check("over_fever", fever, 1'b0);
    last_tick = 1'b0;
    for (int i = 0; i < 8 && !last_tick; i++) step(8'h00);
    check("over_blink_on", mole, 8'hFF);
    step(8'h01);
    check("over_press_hit", hit, 1'b0);
    check("over_press_miss", miss, 1'b0);
    check("over_press_score", score, exp_score);
    check("over_press_mole", mole, 8'hFF);
    step(8'h00);
    last_tick = 1'b0;
    for (int i = 0; i < 8 && !last_tick; i++) step(8'h00);
    check("over_blink_off", mole, 8'h00);

    // Restart from OVER.
    pp = pat_of(m_lfsr);
    start = 1'b1;
    step(8'h00);
    start = 1'b0;
    t = 0; ticks = 0; exp_mole = pp; exp_score = 8'd0;
    check("restart_over", game_over, 1'b0);
    check("restart_score", score, 8'd0);
    check("restart_combo", combo, 4'd0);
    check("restart_timer", timer, GAME_TICKS);
    check("restart_mole", mole, exp_mole);

    // Miss at score 0, then build to 2 and miss on a just-cleared hole.
    if (exp_mole != 8'hFF) begin
      play_cycle(lowest(~exp_mole));
      check("miss0_pulse", miss, 1'b1);
      check("miss0_score", score, 8'd0);
    end else begin
      play_cycle(8'h00);
    end
    play_cycle(8'h00);
    play_cycle(lowest(exp_mole));
    play_cycle(8'h00);
    key = lowest(exp_mole);
    play_cycle(key);
    check("score2", score, 8'd2);
    play_cycle(8'h00);
    play_cycle(key);
    check("miss2_pulse", miss, 1'b1);
    check("miss2_score", score, after_miss(8'd2));

    // Mid-game reset.
    RESET = 1'b1;
    step(8'h5A);
    RESET = 1'b0;
    check("rst_mole", mole, 8'h00);
    check("rst_score", score, 8'd0);
    check("rst_combo", combo, 4'd0);
    check("rst_timer", timer, GAME_TICKS);
    check("rst_over", game_over, 1'b0);
    check("rst_miss", miss, 1'b0);
    step(8'h00);
    check("rst_idle_mole", mole, 8'h00);
    check("rst_idle_hit", hit, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
